slave_send_packet_mc: RTL and testbench
=======================================

Name: slave_send_packet_mc

Overview:
Multi-endpoint USB slave transmit packet sequencer. It accepts a send request for one of NUM_EP endpoint TX FIFOs and arbitrates for the SIE TX port. It then emits the PID byte, then data bytes from the selected FIFO (data PIDs only), then the stop marker. It adds max-packet-size truncation and reports the byte count sent. It sits between the endpoint TX FIFOs and the SIE transmit port arbiter.

Parameters:
NUM_EP, 4, number of endpoint TX FIFOs (1..16)
EP_W, 2, endpoint index width, equal to clog2(NUM_EP) with a minimum of 1
MAX_PKT, 64, maximum data bytes per packet (1..1023)
CNT_W, 10, byte counter width; must hold MAX_PKT

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
PID  in  4  packet ID for the request; sampled when sendPacketWEn is accepted
sendPacketEP  in  EP_W  endpoint index; sampled with PID
sendPacketWEn  in  1  send request strobe, 1 cycle
sendPacketRdy  out  1  idle, ready for a request
SCTxPortReq  out  1  TX port request
SCTxPortGnt  in  1  TX port grant
SCTxPortRdy  in  1  TX port can accept a byte
SCTxPortWEn  out  1  TX byte write strobe
SCTxPortData  out  8  TX byte
SCTxPortCntl  out  8  0x02 = packet start (PID), 0x03 = data, 0x04 = packet stop
fifoData  in  8*NUM_EP  FIFO read data; EP n occupies bits [8n+7:8n]
fifoEmpty  in  NUM_EP  per-EP empty flags
fifoReadEn  out  NUM_EP  per-EP read strobe, one-hot or zero
sentByteCnt  out  CNT_W  data bytes sent in the last packet
maxPktReached  out  1  last packet was stopped by MAX_PKT while the FIFO was not empty

Behaviour:
- Reset values: sendPacketRdy=1. SCTxPortReq, SCTxPortWEn, SCTxPortData, SCTxPortCntl, fifoReadEn, sentByteCnt and maxPktReached are all 0. State=START.
- All outputs are registered and change on the clk edge after the qualifying condition.
- Reset has priority in any state: it aborts the packet and drops SCTxPortReq and all strobes the next cycle.
- States and transitions:
  - START -> IDLE unconditionally.
  - IDLE: on sendPacketWEn, latch PID and EP; sendPacketRdy<=0, SCTxPortReq<=1, cnt<=0, maxPktReached<=0 -> WAIT_GNT. Requests with sendPacketRdy=0 are ignored.
  - WAIT_GNT: SCTxPortGnt=1 -> WAIT_RDY_PID.
  - WAIT_RDY_PID: SCTxPortRdy=1 -> WEn<=1, Data<={~PID,PID}, Cntl<=0x02 -> PID_WR.
  - PID_WR: WEn<=0. Latched PID in {0x3 DATA0, 0xB DATA1, 0x7 DATA2, 0xF MDATA} -> CHK. Any other PID -> FINISH; no stop byte is sent.
  - CHK: if cnt==MAX_PKT, set maxPktReached=~fifoEmpty[ep] -> WAIT_RDY_STOP. Else if fifoEmpty[ep]=0 -> WAIT_RDY_DATA. Else -> WAIT_RDY_STOP.
  - WAIT_RDY_DATA: SCTxPortRdy=1 -> fifoReadEn[ep]<=1 -> FIFO_RD.
  - FIFO_RD: fifoReadEn<=0 -> DATA_WR. FIFO data is valid one cycle after the read strobe.
  - DATA_WR: WEn<=1, Data<=fifoData[ep], Cntl<=0x03, cnt<=cnt+1 -> DATA_CLR.
  - DATA_CLR: WEn<=0 -> CHK.
  - WAIT_RDY_STOP: SCTxPortRdy=1 -> WEn<=1, Data<=0x00, Cntl<=0x04 -> STOP_CLR.
  - STOP_CLR: WEn<=0 -> DONE.
  - FINISH -> DONE.
  - DONE: sentByteCnt<=cnt, sendPacketRdy<=1, SCTxPortReq<=0 -> IDLE.
- Each WEn pulse is exactly 1 cycle. SCTxPortReq is held from IDLE exit until DONE.
- A data PID with an empty FIFO produces a zero-length packet: PID, then stop, sentByteCnt=0.
- A FIFO going empty mid-packet ends the packet normally at CHK.
- Bytes left in the FIFO after truncation are untouched.
- Changes to PID or sendPacketEP after acceptance have no effect on the packet in progress.
- fifoEmpty of other endpoints is ignored.
- SCTxPortGnt deassertion mid-packet is not monitored.

Test Plan:
- ACK, PID=0x2, EP0, Gnt after 3 cycles -> single WEn with Data=0xD2, Cntl=0x02; no 0x04 byte; Req high from the cycle after the request through DONE; sendPacketRdy returns to 1; sentByteCnt=0.
- DATA0 on EP2 with FIFO holding A1,B2,C3 -> fifoReadEn=0b0100 only; writes C3/02, A1/03, B2/03, C3/03, 00/04; sentByteCnt=3; maxPktReached=0.
- DATA1 on EP1 with the FIFO empty -> writes 4B/02 then 00/04 (zero-length packet); no fifoReadEn pulse; sentByteCnt=0.
- MAX_PKT=8, DATA0, 10 bytes queued -> 8 data writes then stop; sentByteCnt=8; maxPktReached=1; FIFO retains 2 bytes. Repeat with exactly 8 bytes -> maxPktReached=0.
- SCTxPortRdy held low for 5 cycles before each byte -> no WEn and no fifoReadEn during the stall; byte order preserved. A second sendPacketWEn issued while busy is ignored.
- Assert rst during DATA_WR of a 4-byte packet -> next cycle all outputs at reset values, sendPacketRdy=1; a following NAK (PID=0xA) request completes with byte 0x5A/02.

Source files
------------

// File: rtl/slave_send_packet_mc_if.sv
// Bus bundle between the endpoint TX FIFOs, the packet sequencer and the
// SIE TX port arbiter. The sequencer uses the slave modport; the environment
// (FIFOs, requester, arbiter) uses the master modport.
//
// Handshakes:
//   sendPacketWEn is a 1-cycle request strobe, accepted only while
//   sendPacketRdy=1. SCTxPortReq is held until the packet is done and
//   SCTxPortGnt is sampled once per packet. A TX byte is written only in a
//   cycle after SCTxPortRdy=1 was seen, as a 1-cycle SCTxPortWEn pulse.
//   fifoReadEn is a 1-cycle strobe; read data is valid the following cycle.
interface slave_send_packet_mc_if #(
  parameter int NUM_EP = 4,
  parameter int EP_W   = 2,
  parameter int CNT_W  = 10
);
  logic [3:0]          PID;
  logic [EP_W-1:0]     sendPacketEP;
  logic                sendPacketWEn;
  logic                sendPacketRdy;
  logic                SCTxPortReq;
  logic                SCTxPortGnt;
  logic                SCTxPortRdy;
  logic                SCTxPortWEn;
  logic [7:0]          SCTxPortData;
  logic [7:0]          SCTxPortCntl;
  logic [8*NUM_EP-1:0] fifoData;
  logic [NUM_EP-1:0]   fifoEmpty;
  logic [NUM_EP-1:0]   fifoReadEn;
  logic [CNT_W-1:0]    sentByteCnt;
  logic                maxPktReached;
  logic [3:0]          dbg_state;

  modport slave (
    input  PID, sendPacketEP, sendPacketWEn, SCTxPortGnt, SCTxPortRdy,
           fifoData, fifoEmpty,
    output sendPacketRdy, SCTxPortReq, SCTxPortWEn, SCTxPortData,
           SCTxPortCntl, fifoReadEn, sentByteCnt, maxPktReached, dbg_state
  );

  modport master (
    output PID, sendPacketEP, sendPacketWEn, SCTxPortGnt, SCTxPortRdy,
           fifoData, fifoEmpty,
    input  sendPacketRdy, SCTxPortReq, SCTxPortWEn, SCTxPortData,
           SCTxPortCntl, fifoReadEn, sentByteCnt, maxPktReached, dbg_state
  );
endinterface

// File: rtl/slave_send_packet_mc.sv
// Multi-endpoint USB slave transmit packet sequencer. Takes a send request for
// one endpoint, wins the SIE TX port, then emits PID, data bytes (data PIDs
// only, capped at MAX_PKT) and the stop marker. Reports bytes sent and whether
// the packet was truncated while the FIFO still held data.
module slave_send_packet_mc #(
  parameter int NUM_EP  = 4,
  parameter int EP_W    = 2,
  parameter int MAX_PKT = 64,
  parameter int CNT_W   = 10
) (
  input logic                   clk,
  input logic                   rst,
  slave_send_packet_mc_if.slave bus
);

  localparam logic [7:0] CNTL_START = 8'h02;
  localparam logic [7:0] CNTL_DATA  = 8'h03;
  localparam logic [7:0] CNTL_STOP  = 8'h04;

  typedef enum logic [3:0] {
    ST_START         = 4'd0,
    ST_IDLE          = 4'd1,
    ST_WAIT_GNT      = 4'd2,
    ST_WAIT_RDY_PID  = 4'd3,
    ST_PID_WR        = 4'd4,
    ST_CHK           = 4'd5,
    ST_WAIT_RDY_DATA = 4'd6,
    ST_FIFO_RD       = 4'd7,
    ST_DATA_WR       = 4'd8,
    ST_DATA_CLR      = 4'd9,
    ST_WAIT_RDY_STOP = 4'd10,
    ST_STOP_CLR      = 4'd11,
    ST_FINISH        = 4'd12,
    ST_DONE          = 4'd13
  } state_t;

  state_t            state_q;
  logic [3:0]        pid_q;
  logic [EP_W-1:0]   ep_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              rdy_q;
  logic              req_q;
  logic              wen_q;
  logic [7:0]        data_q;
  logic [7:0]        cntl_q;
  logic [NUM_EP-1:0] rd_en_q;
  logic [CNT_W-1:0]  sent_q;
  logic              max_q;

  logic [7:0]        fifo_byte;
  logic              fifo_empty_sel;
  logic [NUM_EP-1:0] rd_onehot;
  logic              is_data_pid;

  // DATA0/1/2 and MDATA are exactly the PIDs with the two low bits set.
  assign is_data_pid = (pid_q[1:0] == 2'b11);

  // Select the latched endpoint's data byte, empty flag and read strobe lane.
  always_comb begin
    fifo_byte      = 8'h00;
    fifo_empty_sel = 1'b1;
    rd_onehot      = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (ep_q == EP_W'(i)) begin
        fifo_byte      = bus.fifoData[8*i +: 8];
        fifo_empty_sel = bus.fifoEmpty[i];
        rd_onehot[i]   = 1'b1;
      end
    end
  end

  // Packet sequencer: one state register with all outputs registered alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_START;
      pid_q   <= 4'h0;
      ep_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      data_q  <= 8'h00;
      cntl_q  <= 8'h00;
      rd_en_q <= '0;
      sent_q  <= '0;
      max_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_START: state_q <= ST_IDLE;

        ST_IDLE: begin
          if (bus.sendPacketWEn && rdy_q) begin
            pid_q   <= bus.PID;
            ep_q    <= bus.sendPacketEP;
            rdy_q   <= 1'b0;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            max_q   <= 1'b0;
            state_q <= ST_WAIT_GNT;
          end
        end

        ST_WAIT_GNT: begin
          if (bus.SCTxPortGnt) state_q <= ST_WAIT_RDY_PID;
        end

        ST_WAIT_RDY_PID: begin
          if (bus.SCTxPortRdy) begin
            wen_q   <= 1'b1;
            data_q  <= {~pid_q, pid_q};
            cntl_q  <= CNTL_START;
            state_q <= ST_PID_WR;
          end
        end

        // Handshake PIDs carry no payload and no stop marker.
        ST_PID_WR: begin
          wen_q   <= 1'b0;
          state_q <= is_data_pid ? ST_CHK : ST_FINISH;
        end

        ST_CHK: begin
          if (cnt_q == CNT_W'(MAX_PKT)) begin
            max_q   <= ~fifo_empty_sel;
            state_q <= ST_WAIT_RDY_STOP;
          end else if (!fifo_empty_sel) begin
            state_q <= ST_WAIT_RDY_DATA;
          end else begin
            state_q <= ST_WAIT_RDY_STOP;
          end
        end

        ST_WAIT_RDY_DATA: begin
          if (bus.SCTxPortRdy) begin
            rd_en_q <= rd_onehot;
            state_q <= ST_FIFO_RD;
          end
        end

        // FIFO output becomes valid the cycle after the strobe.
        ST_FIFO_RD: begin
          rd_en_q <= '0;
          state_q <= ST_DATA_WR;
        end

        ST_DATA_WR: begin
          wen_q   <= 1'b1;
          data_q  <= fifo_byte;
          cntl_q  <= CNTL_DATA;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= ST_DATA_CLR;
        end

        ST_DATA_CLR: begin
          wen_q   <= 1'b0;
          state_q <= ST_CHK;
        end

        ST_WAIT_RDY_STOP: begin
          if (bus.SCTxPortRdy) begin
            wen_q   <= 1'b1;
            data_q  <= 8'h00;
            cntl_q  <= CNTL_STOP;
            state_q <= ST_STOP_CLR;
          end
        end

        ST_STOP_CLR: begin
          wen_q   <= 1'b0;
          state_q <= ST_DONE;
        end

        ST_FINISH: state_q <= ST_DONE;

        ST_DONE: begin
          sent_q  <= cnt_q;
          rdy_q   <= 1'b1;
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_START;
      endcase
    end
  end

  assign bus.sendPacketRdy = rdy_q;
  assign bus.SCTxPortReq   = req_q;
  assign bus.SCTxPortWEn   = wen_q;
  assign bus.SCTxPortData  = data_q;
  assign bus.SCTxPortCntl  = cntl_q;
  assign bus.fifoReadEn    = rd_en_q;
  assign bus.sentByteCnt   = sent_q;
  assign bus.maxPktReached = max_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_slave_send_packet_mc.sv
// Directed bench for slave_send_packet_mc with MAX_PKT=8. Models four
// registered-output endpoint FIFOs and a TX port whose ready can stall.
module tb_slave_send_packet_mc;

  localparam int NUM_EP  = 4;
  localparam int EP_W    = 2;
  localparam int MAX_PKT = 8;
  localparam int CNT_W   = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slave_send_packet_mc_if #(.NUM_EP(NUM_EP), .EP_W(EP_W), .CNT_W(CNT_W)) bus ();

  slave_send_packet_mc #(
    .NUM_EP(NUM_EP), .EP_W(EP_W), .MAX_PKT(MAX_PKT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- endpoint FIFO model ----------------
  logic [7:0] mem [NUM_EP][64];
  int         wr_ptr [NUM_EP];
  int         rd_ptr [NUM_EP];
  logic [7:0] fifo_out [NUM_EP];

  always @(posedge clk) begin
    for (int e = 0; e < NUM_EP; e++) begin
      if (bus.fifoReadEn[e] && rd_ptr[e] != wr_ptr[e]) begin
        fifo_out[e] <= mem[e][rd_ptr[e]];
        rd_ptr[e]   <= rd_ptr[e] + 1;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < NUM_EP; e++) bus.fifoEmpty[e] = (rd_ptr[e] == wr_ptr[e]);
  end
  assign bus.fifoData = {fifo_out[3], fifo_out[2], fifo_out[1], fifo_out[0]};

  task automatic push(input int e, input logic [7:0] b);
    mem[e][wr_ptr[e]] = b;
    wr_ptr[e] = wr_ptr[e] + 1;
  endtask

  // ---------------- TX port model, monitor ----------------
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          rd_cnt [NUM_EP];
  int          viol = 0;
  logic        rdy_r = 1'b1;
  bit          stall_en = 0;
  bit          stall_en_d = 0;
  int          scnt = 0;

  assign bus.SCTxPortRdy = rdy_r;

  always @(negedge clk) begin
    if (bus.SCTxPortWEn) obs_q.push_back({bus.SCTxPortCntl, bus.SCTxPortData});
    for (int e = 0; e < NUM_EP; e++) if (bus.fifoReadEn[e]) rd_cnt[e]++;
    // rdy_r still holds the value the DUT saw at the preceding posedge.
    if ((bus.SCTxPortWEn || (|bus.fifoReadEn)) && !rdy_r) viol++;
    if (!stall_en) begin
      rdy_r = 1'b1;
    end else if ((stall_en && !stall_en_d) || bus.SCTxPortWEn) begin
      rdy_r = 1'b0;
      scnt  = 0;
    end else if (!rdy_r) begin
      scnt++;
      if (scnt >= 5) rdy_r = 1'b1;
    end
    stall_en_d = stall_en;
  end

  // ---------------- driver ----------------
  task automatic run_packet(input logic [3:0] pid, input logic [EP_W-1:0] ep,
                            input int gnt_delay, input int dup_cycle,
                            output bit timeout, output bit req_gap);
    int k;
    timeout = 0;
    req_gap = 0;
    @(negedge clk);
    bus.PID = pid;
    bus.sendPacketEP = ep;
    bus.sendPacketWEn = 1'b1;
    @(negedge clk);
    bus.sendPacketWEn = 1'b0;
    bus.PID = 4'h0;
    bus.sendPacketEP = ~ep;
    k = 0;
    while (!bus.sendPacketRdy && !timeout) begin
      if (!bus.SCTxPortReq) req_gap = 1;
      if (k == gnt_delay) bus.SCTxPortGnt = 1'b1;
      if (dup_cycle != 0 && k == dup_cycle) begin
        bus.sendPacketWEn = 1'b1;
        bus.PID = 4'h2;
        bus.sendPacketEP = 2'd0;
      end else begin
        bus.sendPacketWEn = 1'b0;
      end
      @(negedge clk);
      k++;
      if (k > 600) timeout = 1;
    end
    bus.SCTxPortGnt = 1'b0;
    bus.sendPacketWEn = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.sendPacketRdy, bus.SCTxPortReq, bus.SCTxPortWEn, bus.maxPktReached} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b want 1000",
        {bus.sendPacketRdy, bus.SCTxPortReq, bus.SCTxPortWEn, bus.maxPktReached});
    end
    checks++;
    if ({bus.SCTxPortData, bus.SCTxPortCntl} !== 16'h0000) begin
      errors++; $display("FAIL reset_data_cntl: got %h want 0000", {bus.SCTxPortData, bus.SCTxPortCntl});
    end
    checks++;
    if (bus.fifoReadEn !== 4'b0000 || bus.sentByteCnt !== 10'd0) begin
      errors++; $display("FAIL reset_rd_cnt: got rd=%b cnt=%0d want 0000/0", bus.fifoReadEn, bus.sentByteCnt);
    end
    checks++;
    if (bus.dbg_state !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dbg_state !== 4'd1 || bus.sendPacketRdy !== 1'b1) begin
      errors++; $display("FAIL reset_to_idle: got state=%0d rdy=%b want 1/1", bus.dbg_state, bus.sendPacketRdy);
    end
  endtask

  task automatic test_data0;
    bit to, gap;
    int r0, r1, r2, r3;
    push(2, 8'hA1); push(2, 8'hB2); push(2, 8'hC3);
    obs_q.delete(); exp_q.delete();
    exp_q.push_back(16'h02C3); exp_q.push_back(16'h03A1);
    exp_q.push_back(16'h03B2); exp_q.push_back(16'h03C3); exp_q.push_back(16'h0400);
    r0 = rd_cnt[0]; r1 = rd_cnt[1]; r2 = rd_cnt[2]; r3 = rd_cnt[3];
    run_packet(4'h3, 2'd2, 1, 0, to, gap);
    checks++;
    if (to) begin errors++; $display("FAIL data0_timeout: got timeout want done"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL data0_len: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL data0_byte%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    checks++;
    if (rd_cnt[2] - r2 != 3 || rd_cnt[0] != r0 || rd_cnt[1] != r1 || rd_cnt[3] != r3) begin
      errors++; $display("FAIL data0_reads: got ep2=%0d others=%0d want 3/0", rd_cnt[2] - r2,
        (rd_cnt[0] - r0) + (rd_cnt[1] - r1) + (rd_cnt[3] - r3));
    end
    checks++;
    if (bus.sentByteCnt !== 10'd3 || bus.maxPktReached !== 1'b0) begin
      errors++; $display("FAIL data0_cnt: got cnt=%0d max=%b want 3/0", bus.sentByteCnt, bus.maxPktReached);
    end
  endtask

  task automatic test_ack;
    bit to, gap;
    obs_q.delete();
    run_packet(4'h2, 2'd0, 3, 0, to, gap);
    checks++;
    if (to) begin errors++; $display("FAIL ack_timeout: got timeout want done"); end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 16'h02D2) begin
      errors++; $display("FAIL ack_write: got n=%0d first=%h want 1/02d2", obs_q.size(), obs_q[0]);
    end
    checks++;
    if (gap) begin errors++; $display("FAIL ack_req_held: got req gap want req high"); end
    checks++;
    if (bus.sentByteCnt !== 10'd0 || bus.SCTxPortReq !== 1'b0 || bus.sendPacketRdy !== 1'b1) begin
      errors++; $display("FAIL ack_done: got cnt=%0d req=%b rdy=%b want 0/0/1",
        bus.sentByteCnt, bus.SCTxPortReq, bus.sendPacketRdy);
    end
  endtask

  task automatic test_empty;
    bit to, gap;
    int r1;
    obs_q.delete();
    r1 = rd_cnt[1];
    run_packet(4'hB, 2'd1, 0, 0, to, gap);
    checks++;
    if (to) begin errors++; $display("FAIL empty_timeout: got timeout want done"); end
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 16'h024B || obs_q[1] !== 16'h0400) begin
      errors++; $display("FAIL empty_writes: got n=%0d %h %h want 2 024b 0400", obs_q.size(), obs_q[0], obs_q[1]);
    end
    checks++;
    if (rd_cnt[1] != r1 || bus.sentByteCnt !== 10'd0) begin
      errors++; $display("FAIL empty_reads_cnt: got reads=%0d cnt=%0d want 0/0", rd_cnt[1] - r1, bus.sentByteCnt);
    end
  endtask

  task automatic test_trunc;
    bit to, gap;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) push(3, 8'h10 + 8'(i));
    exp_q.push_back(16'h02C3);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0310 + 16'(i));
    exp_q.push_back(16'h0400);
    run_packet(4'h3, 2'd3, 2, 0, to, gap);
    checks++;
    if (to) begin errors++; $display("FAIL trunc_timeout: got timeout want done"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL trunc_len: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL trunc_byte%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    checks++;
    if (bus.sentByteCnt !== 10'd8 || bus.maxPktReached !== 1'b1) begin
      errors++; $display("FAIL trunc_cnt: got cnt=%0d max=%b want 8/1", bus.sentByteCnt, bus.maxPktReached);
    end
    checks++;
    if (wr_ptr[3] - rd_ptr[3] != 2) begin
      errors++; $display("FAIL trunc_left: got %0d bytes left want 2", wr_ptr[3] - rd_ptr[3]);
    end
  endtask

  task automatic test_exact;
    bit to, gap;
    obs_q.delete();
    for (int i = 0; i < 8; i++) push(0, 8'h20 + 8'(i));
    run_packet(4'h7, 2'd0, 1, 0, to, gap);
    checks++;
    if (to) begin errors++; $display("FAIL exact_timeout: got timeout want done"); end
    checks++;
    if (obs_q.size() != 10 || obs_q[0] !== 16'h0287 || obs_q[8] !== 16'h0327 || obs_q[9] !== 16'h0400) begin
      errors++; $display("FAIL exact_writes: got n=%0d %h %h %h want 10 0287 0327 0400",
        obs_q.size(), obs_q[0], obs_q[8], obs_q[9]);
    end
    checks++;
    if (bus.sentByteCnt !== 10'd8 || bus.maxPktReached !== 1'b0) begin
      errors++; $display("FAIL exact_cnt: got cnt=%0d max=%b want 8/0", bus.sentByteCnt, bus.maxPktReached);
    end
  endtask

  task automatic test_stall;
    bit to, gap;
    int v0, n;
    obs_q.delete(); exp_q.delete();
    push(1, 8'h55); push(1, 8'h66);
    exp_q.push_back(16'h020F); exp_q.push_back(16'h0355);
    exp_q.push_back(16'h0366); exp_q.push_back(16'h0400);
    v0 = viol;
    stall_en = 1;
    run_packet(4'hF, 2'd1, 1, 10, to, gap);
    stall_en = 0;
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: got timeout want done"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_len: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_byte%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    checks++;
    if (viol != v0) begin
      errors++; $display("FAIL stall_rdy: got %0d strobes while not ready want 0", viol - v0);
    end
    n = obs_q.size();
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() != n || bus.sendPacketRdy !== 1'b1 || bus.SCTxPortReq !== 1'b0) begin
      errors++; $display("FAIL stall_dup_ignored: got extra=%0d rdy=%b req=%b want 0/1/0",
        obs_q.size() - n, bus.sendPacketRdy, bus.SCTxPortReq);
    end
    checks++;
    if (bus.sentByteCnt !== 10'd2) begin
      errors++; $display("FAIL stall_cnt: got %0d want 2", bus.sentByteCnt);
    end
  endtask

  task automatic test_reset_mid;
    bit to, gap;
    int k;
    obs_q.delete();
    push(2, 8'h01); push(2, 8'h02); push(2, 8'h03); push(2, 8'h04);
    @(negedge clk);
    bus.PID = 4'h3; bus.sendPacketEP = 2'd2; bus.sendPacketWEn = 1'b1;
    @(negedge clk);
    bus.sendPacketWEn = 1'b0; bus.SCTxPortGnt = 1'b1;
    k = 0;
    while (!bus.fifoReadEn[2] && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (k >= 200) begin errors++; $display("FAIL rstmid_timeout: got no read strobe want one"); end
    @(negedge clk);
    checks++;
    if (bus.dbg_state !== 4'd8) begin
      errors++; $display("FAIL rstmid_in_data_wr: got state=%0d want 8", bus.dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.sendPacketRdy, bus.SCTxPortReq, bus.SCTxPortWEn, bus.maxPktReached} !== 4'b1000 ||
        bus.fifoReadEn !== 4'b0000 || {bus.SCTxPortData, bus.SCTxPortCntl} !== 16'h0000) begin
      errors++; $display("FAIL rstmid_outputs: got rdy/req/wen/max=%b rd=%b data/cntl=%h want 1000 0000 0000",
        {bus.sendPacketRdy, bus.SCTxPortReq, bus.SCTxPortWEn, bus.maxPktReached},
        bus.fifoReadEn, {bus.SCTxPortData, bus.SCTxPortCntl});
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL rstmid_no_data_byte: got %0d writes want 1", obs_q.size());
    end
    rst = 1'b0;
    bus.SCTxPortGnt = 1'b0;
    repeat (3) @(negedge clk);
    obs_q.delete();
    run_packet(4'hA, 2'd0, 1, 0, to, gap);
    checks++;
    if (to) begin errors++; $display("FAIL nak_timeout: got timeout want done"); end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 16'h025A) begin
      errors++; $display("FAIL nak_write: got n=%0d first=%h want 1/025a", obs_q.size(), obs_q[0]);
    end
  endtask

  initial begin
    bus.PID = 4'h0;
    bus.sendPacketEP = '0;
    bus.sendPacketWEn = 1'b0;
    bus.SCTxPortGnt = 1'b0;
    test_reset();
    test_data0();
    test_ack();
    test_empty();
    test_trunc();
    test_exact();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
